main_vc_dispatch: RTL

// - Consumer stage directly downstream of the Main FIFO: pops words from Main and routes each to VC0 or VC1 FIFO by its class bit.
// - Issues Main reads only when Main holds data and neither VC FIFO signals almost-full.
// - Keeps per-VC word counters and a sticky overflow error for QoS observation.

---
 rtl/main_vc_dispatch_if.sv | 42 ++++
 rtl/main_vc_dispatch.sv | 90 +++++++++
 2 files changed

// File: rtl/main_vc_dispatch_if.sv
// Main FIFO read port and VC0/VC1 FIFO write ports seen by the dispatcher.
// master = dispatcher side, slave = FIFO side.
interface main_vc_dispatch_if #(
  parameter int BW = 6
);
  logic [BW-1:0] Main_data_out;
  logic          Main_empty;
  logic          Main_rd;
  logic          VC0_almost_full;
  logic          VC1_almost_full;
  logic          VC0_full;
  logic          VC1_full;
  logic          VC0_wr;
  logic          VC1_wr;
  logic [BW-1:0] VC_data_in;

  modport master (
    input  Main_data_out,
    input  Main_empty,
    output Main_rd,
    input  VC0_almost_full,
    input  VC1_almost_full,
    input  VC0_full,
    input  VC1_full,
    output VC0_wr,
    output VC1_wr,
    output VC_data_in
  );

  modport slave (
    output Main_data_out,
    output Main_empty,
    input  Main_rd,
    output VC0_almost_full,
    output VC1_almost_full,
    output VC0_full,
    output VC1_full,
    input  VC0_wr,
    input  VC1_wr,
    input  VC_data_in
  );
endinterface

// File: rtl/main_vc_dispatch.sv
// Pops words from the Main FIFO and routes each to VC0/VC1 by its class bit,
// with per-VC word counters and a sticky drop error.
module main_vc_dispatch #(
  parameter int BW     = 6,
  parameter int VC_BIT = 5,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset_L,
  main_vc_dispatch_if.master bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] VC0_count,
  output logic [CNT_W-1:0] VC1_count,
  output logic             dispatch_error,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } state_t;

  state_t st;
  logic   rd_q;
  logic   any_af;
  logic   tgt;
  logic   push0;
  logic   push1;
  logic   drop;

  assign any_af = bus.VC0_almost_full | bus.VC1_almost_full;
  assign state  = st;

  assign bus.Main_rd = (st == ACTIVE) & ~bus.Main_empty & ~any_af;

  // Word popped last cycle is on Main_data_out now.
  assign tgt   = bus.Main_data_out[VC_BIT];
  assign push0 = rd_q & ~tgt & ~bus.VC0_full;
  assign push1 = rd_q &  tgt & ~bus.VC1_full;
  assign drop  = rd_q & (tgt ? bus.VC1_full : bus.VC0_full);

  assign bus.VC0_wr     = push0;
  assign bus.VC1_wr     = push1;
  assign bus.VC_data_in = rd_q ? bus.Main_data_out : '0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st   <= IDLE;
      rd_q <= 1'b0;
    end else begin
      rd_q <= bus.Main_rd;
      unique case (st)
        IDLE: begin
          if (!bus.Main_empty)
            st <= any_af ? STALL : ACTIVE;
        end
        ACTIVE: begin
          if (bus.Main_empty)
            st <= IDLE;
          else if (any_af)
            st <= STALL;
        end
        STALL: begin
          if (!any_af)
            st <= bus.Main_empty ? IDLE : ACTIVE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      VC0_count      <= '0;
      VC1_count      <= '0;
      dispatch_error <= 1'b0;
    end else begin
      if (cnt_clr) begin
        VC0_count <= '0;
        VC1_count <= '0;
      end else begin
        if (push0) VC0_count <= VC0_count + 1'b1;
        if (push1) VC1_count <= VC1_count + 1'b1;
      end
      if (drop) dispatch_error <= 1'b1;
    end
  end

endmodule
